pipe_stage_chain: RTL

PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

---
 rtl/pipe_stage_chain.sv | 100 ++++++++++
 1 files changed

// File: rtl/pipe_stage_chain.sv
// Multi-stage valid/ready pipeline with per-stage stall and flush controls,
// collapsing bubbles, and producer-stall / retirement counters.
module pipe_stage_chain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic [DEPTH-1:0] stall_req,
    input  logic [DEPTH-1:0] flush_mask,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [DEPTH-1:0] stage_valid,
    output logic [15:0]      stall_cnt,
    output logic [31:0]      retire_cnt
);

    logic [DEPTH-1:0] valid_vec;
    logic [WIDTH-1:0] data_arr [DEPTH];
    logic [DEPTH-1:0] veff;
    logic [DEPTH-1:0] hold;
    logic [15:0]      stall_cnt_reg;
    logic [31:0]      retire_cnt_reg;
    logic             retire;
    logic             blocked;

    // A flushed entry counts as absent for every hold/transfer decision.
    assign veff = valid_vec & ~flush_mask;

    // Hold propagates upstream only through occupied stages, so bubbles collapse.
    always_comb begin
        hold            = '0;
        hold[DEPTH-1]   = stall_req[DEPTH-1] | (veff[DEPTH-1] & ~out_ready);
        for (int k = DEPTH - 2; k >= 0; k--) begin
            hold[k] = stall_req[k] | (veff[k] & hold[k+1]);
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic             valid_reg;
        logic [WIDTH-1:0] data_reg;
        logic             take;
        logic [WIDTH-1:0] src;

        if (gi == 0) begin : g_head
            assign take = in_valid;
            assign src  = in_data;
        end else begin : g_body
            assign take = veff[gi-1] & ~hold[gi-1];
            assign src  = data_arr[gi-1];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_reg <= 1'b0;
                data_reg  <= '0;
            end else if (hold[gi]) begin
                valid_reg <= veff[gi];
            end else begin
                valid_reg <= take;
                if (take) begin
                    data_reg <= src;
                end
            end
        end

        assign valid_vec[gi] = valid_reg;
        assign data_arr[gi]  = data_reg;
    end

    assign in_ready    = ~hold[0];
    assign out_valid   = veff[DEPTH-1] & ~stall_req[DEPTH-1];
    assign out_data    = data_arr[DEPTH-1];
    assign stage_valid = valid_vec;

    assign retire  = out_valid & out_ready;
    assign blocked = in_valid & ~in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_reg  <= '0;
            retire_cnt_reg <= '0;
        end else begin
            if (blocked && (stall_cnt_reg != 16'hFFFF)) begin
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            end
            if (retire) begin
                retire_cnt_reg <= retire_cnt_reg + 32'd1;
            end
        end
    end

    assign stall_cnt  = stall_cnt_reg;
    assign retire_cnt = retire_cnt_reg;

endmodule
